// File: rtl/lfsr_seq_checker.sv
// Checks an incoming 16-bit LFSR word stream: searches, verifies, locks onto
// the sequence, and flags/counts words that break it while locked.
module lfsr_seq_checker #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din_valid,
    input  logic [15:0] din,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_count,
    output logic [15:0] word_count
);

    localparam int GW = (LOCK_COUNT   > 1) ? $clog2(LOCK_COUNT + 1)   : 1;
    localparam int MW = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT + 1) : 1;
    localparam logic [15:0] RESEED_WORD = 16'h8000;
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ref_q, ref_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [MW-1:0] miss_run_q, miss_run_d;
    logic        locked_q, locked_d;
    logic        err_q, err_d;
    logic [15:0] err_count_q, err_count_d;
    logic [15:0] word_count_q, word_count_d;

    logic [15:0] expected_word;
    logic        word_match;
    logic        reseed;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], ~(x[15] ^ x[14] ^ x[12] ^ x[3])};
    endfunction

    assign expected_word = lfsr_next(ref_q);
    assign word_match    = (din == expected_word);
    // The generator may reseed from 8000, so the word after it is unpredictable.
    assign reseed        = (ref_q == RESEED_WORD);

    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        good_cnt_d   = good_cnt_q;
        miss_run_d   = miss_run_q;
        err_d        = 1'b0;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;

        if (din_valid) begin
            ref_d = din;
            case (state_q)
                SEARCH: begin
                    good_cnt_d = '0;
                    state_d    = VERIFY;
                end
                VERIFY: begin
                    if (!reseed) begin
                        if (word_match) begin
                            good_cnt_d = good_cnt_q + 1'b1;
                            if (good_cnt_q == GW'(LOCK_COUNT - 1)) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            good_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (!reseed) begin
                        if (word_match) begin
                            miss_run_d = '0;
                        end else begin
                            err_d = 1'b1;
                            if (miss_run_q == MW'(UNLOCK_COUNT - 1)) begin
                                miss_run_d = '0;
                                state_d    = SEARCH;
                            end else begin
                                miss_run_d = miss_run_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase

            if (word_count_q != CNT_MAX) begin
                word_count_d = word_count_q + 16'd1;
            end
        end

        if (err_d && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + 16'd1;
        end

        // Clearing wins over any increment in the same cycle.
        if (clr_cnt) begin
            err_count_d  = '0;
            word_count_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= SEARCH;
            ref_q        <= '0;
            good_cnt_q   <= '0;
            miss_run_q   <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            good_cnt_q   <= good_cnt_d;
            miss_run_q   <= miss_run_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
        end
    end

    assign locked     = locked_q;
    assign err        = err_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker; expected values are hand-derived from
// the successor function next(x) = {x[14:0], ~(x15^x14^x12^x3)}.
module tb_lfsr_seq_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        din_valid;
    logic [15:0] din;
    logic        clr_cnt;
    logic        locked;
    logic        err;
    logic [15:0] err_count;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_pass   = 0;

    lfsr_seq_checker #(
        .LOCK_COUNT   (4),
        .UNLOCK_COUNT (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .din        (din),
        .clr_cnt    (clr_cnt),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %04h expected %04h", tag, got, exp);
        end
    endtask

    // One valid word per call; outputs are sampled 1 time unit after the edge.
    task automatic send(input logic [15:0] w, input logic clr);
        din       = w;
        din_valid = 1'b1;
        clr_cnt   = clr;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        $display("tx din=%04h clr=%0b -> locked=%0b err=%0b err_count=%0d word_count=%0d",
                 w, clr, locked, err, err_count, word_count);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic send_lock_prefix();
        // 0000 -> 0001 -> 0003 -> 0007 -> 000F : lock on the fifth word
        send(16'h0000, 1'b0);
        send(16'h0001, 1'b0);
        send(16'h0003, 1'b0);
        send(16'h0007, 1'b0);
        check("prefix_not_yet_locked", 16'(locked), 16'd0);
        send(16'h000F, 1'b0);
        check("prefix_locked", 16'(locked), 16'd1);
    endtask

    initial begin
        reset     = 1'b0;
        din_valid = 1'b1;
        din       = 16'h1234;
        clr_cnt   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", 16'(locked), 16'd0);
        check("rst_err", 16'(err), 16'd0);
        check("rst_err_count", err_count, 16'h0000);
        check("rst_word_count", word_count, 16'h0000);
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;

        // Basic lock sequence
        send(16'h0001, 1'b0);
        check("lock_w1_locked", 16'(locked), 16'd0);
        check("lock_w1_word_count", word_count, 16'd1);
        send(16'h0003, 1'b0);
        send(16'h0007, 1'b0);
        send(16'h000F, 1'b0);
        check("lock_w4_locked", 16'(locked), 16'd0);
        send(16'h001E, 1'b0);
        check("lock_w5_locked", 16'(locked), 16'd1);
        check("lock_w5_err", 16'(err), 16'd0);
        send(16'h003C, 1'b0);
        check("lock_w6_err", 16'(err), 16'd0);
        check("lock_err_count", err_count, 16'd0);
        check("lock_word_count", word_count, 16'd6);
        @(posedge clk);
        #1;
        check("idle_word_count_hold", word_count, 16'd6);

        // Single corruption while locked
        do_reset();
        send_lock_prefix();
        send(16'h1234, 1'b0);
        check("corrupt_err_1234", 16'(err), 16'd1);
        send(16'h003C, 1'b0);
        check("corrupt_err_003c", 16'(err), 16'd1);
        send(16'h0078, 1'b0);
        check("corrupt_err_0078", 16'(err), 16'd0);
        check("corrupt_locked", 16'(locked), 16'd1);
        check("corrupt_err_count", err_count, 16'd2);
        check("corrupt_word_count", word_count, 16'd8);

        // Loss of lock: three non-successors (next(1111)=2222, so 3333 and 5555 are used)
        send(16'h1111, 1'b0);
        check("loss_err1", 16'(err), 16'd1);
        check("loss_locked1", 16'(locked), 16'd1);
        send(16'h3333, 1'b0);
        check("loss_err2", 16'(err), 16'd1);
        check("loss_locked2", 16'(locked), 16'd1);
        send(16'h5555, 1'b0);
        check("loss_err3", 16'(err), 16'd1);
        check("loss_locked3", 16'(locked), 16'd0);
        check("loss_err_count", err_count, 16'd5);
        @(posedge clk);
        #1;
        check("idle_err_low", 16'(err), 16'd0);
        // In SEARCH, a correct successor pair must not relock
        send(16'h0001, 1'b0);
        send(16'h0003, 1'b0);
        check("search_no_err", 16'(err), 16'd0);
        check("search_not_locked", 16'(locked), 16'd0);

        // Reseed exemption: 4000 (error), 8000 = next(4000), 5A5A exempt, B4B4 = next(5A5A)
        do_reset();
        send_lock_prefix();
        send(16'h4000, 1'b0);
        check("reseed_4000_err", 16'(err), 16'd1);
        send(16'h8000, 1'b0);
        check("reseed_8000_err", 16'(err), 16'd0);
        check("reseed_wc_before", word_count, 16'd7);
        send(16'h5A5A, 1'b0);
        check("reseed_5a5a_err", 16'(err), 16'd0);
        check("reseed_5a5a_locked", 16'(locked), 16'd1);
        send(16'hB4B4, 1'b0);
        check("reseed_b4b4_err", 16'(err), 16'd0);
        check("reseed_b4b4_locked", 16'(locked), 16'd1);
        check("reseed_wc_after", word_count, 16'd9);
        check("reseed_err_count", err_count, 16'd1);

        // clr_cnt on the same cycle as an erroring word
        send(16'h1234, 1'b1);
        check("clr_err_pulse", 16'(err), 16'd1);
        check("clr_err_count", err_count, 16'd0);
        check("clr_word_count", word_count, 16'd0);
        check("clr_locked_kept", 16'(locked), 16'd1);
        send(16'h2468, 1'b0);
        check("clr_next_err", 16'(err), 16'd0);
        check("clr_next_err_count", err_count, 16'd0);
        check("clr_next_word_count", word_count, 16'd1);

        // Reset mid-LOCKED with a mismatching valid word present
        din       = 16'h0000;
        din_valid = 1'b1;
        reset     = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        din_valid = 1'b0;
        check("midrst_locked", 16'(locked), 16'd0);
        check("midrst_err", 16'(err), 16'd0);
        check("midrst_err_count", err_count, 16'd0);
        check("midrst_word_count", word_count, 16'd0);
        send(16'h0001, 1'b0);
        send(16'h0003, 1'b0);
        send(16'h0007, 1'b0);
        send(16'h000F, 1'b0);
        check("relock_w4_locked", 16'(locked), 16'd0);
        send(16'h001E, 1'b0);
        check("relock_w5_locked", 16'(locked), 16'd1);

        // Saturation: clear, then stream 65535 words of 0000 (three errors then SEARCH/VERIFY)
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("sat_clr_word_count", word_count, 16'd0);
        check("sat_clr_locked", 16'(locked), 16'd1);
        din       = 16'h0000;
        din_valid = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        din_valid = 1'b0;
        check("sat_word_count_max", word_count, 16'hFFFF);
        check("sat_err_count", err_count, 16'd3);
        check("sat_locked", 16'(locked), 16'd0);
        send(16'h0000, 1'b0);
        send(16'h0000, 1'b0);
        send(16'h0000, 1'b0);
        check("sat_word_count_hold", word_count, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
